eh2_lsu_ecc_scrub: RTL

- Sits directly downstream of the LSU ECC check stage.
- Consumes the dc3 single-bit-error indications and their corrected (SEC) data, and queues the corrected words.
- Writes the corrected words back into the DCCM through a request/grant port on the DCCM write arbiter.
- Drops queued corrections that a younger store makes stale, and keeps a saturating count of corrections performed.

---
 rtl/eh2_lsu_ecc_scrub.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/eh2_lsu_ecc_scrub.sv
// eh2_lsu_ecc_scrub
//   Queues single-bit-error corrections reported by the LSU ECC check stage
//   and writes the corrected words back into the DCCM through the DCCM write
//   arbiter. Queued corrections made stale by a younger store are discarded.
//   A saturating counter tracks the number of corrections accepted.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   scrub_en                 enable capture of new corrections
//   kill_dc3                 dc3 instruction flushed/faulted, suppress capture
//   err_{lo,hi}_dc3          single-bit error flags per bank word
//   addr_{lo,hi}_dc3         byte addresses of the corrected words
//   sec_data_{lo,hi}_dc3     corrected data
//   st_wen, st_addr          store buffer / DMA DCCM write this cycle
//   wb_req, wb_addr, wb_data writeback request to the arbiter (word aligned)
//   wb_gnt                   arbiter grant, write happens this cycle
//   q_full                   no free queue entry
//   err_count                saturating count of accepted corrections
//   overflow                 one-cycle pulse when a correction was dropped
module eh2_lsu_ecc_scrub #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DEPTH           = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scrub_en,
  input  logic                       kill_dc3,
  input  logic                       err_lo_dc3,
  input  logic                       err_hi_dc3,
  input  logic [DCCM_BITS-1:0]       addr_lo_dc3,
  input  logic [DCCM_BITS-1:0]       addr_hi_dc3,
  input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_dc3,
  input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_dc3,
  input  logic                       st_wen,
  input  logic [DCCM_BITS-1:0]       st_addr,
  output logic                       wb_req,
  output logic [DCCM_BITS-1:0]       wb_addr,
  output logic [DCCM_DATA_WIDTH-1:0] wb_data,
  input  logic                       wb_gnt,
  output logic                       q_full,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int WW = DCCM_BITS - 2;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_nxt;

  // Writes are word granular, so byte-offset bits never take part.
  logic unused_bits;
  assign unused_bits = ^{addr_lo_dc3[1:0], addr_hi_dc3[1:0], st_addr[1:0]};

  logic                       cap_lo, cap_hi;
  logic                       stg_lo_v, stg_hi_v;
  logic [WW-1:0]              stg_lo_word, stg_hi_word;
  logic [DCCM_DATA_WIDTH-1:0] stg_lo_data, stg_hi_data;

  logic [WW-1:0]              q_word [DEPTH];
  logic [DCCM_DATA_WIDTH-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]           q_vld, q_vld_nxt;
  logic [PW-1:0]              rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt, wr_hi_ptr;
  logic [OW-1:0]              occ, occ_nxt, free;

  logic [WW-1:0]              st_word;
  logic                       pop, cand_lo, cand_hi, acc_lo, acc_hi, drop;
  logic [1:0]                 n_acc;
  logic [CNT_WIDTH:0]         cnt_sum;
  logic                       head_ready_nxt;

  assign cap_lo  = err_lo_dc3 & scrub_en & ~kill_dc3;
  assign cap_hi  = err_hi_dc3 & scrub_en & ~kill_dc3;
  assign st_word = st_addr[DCCM_BITS-1:2];

  // One-deep staging register between the check stage and the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_lo_v    <= 1'b0;
      stg_hi_v    <= 1'b0;
      stg_lo_word <= '0;
      stg_hi_word <= '0;
      stg_lo_data <= '0;
      stg_hi_data <= '0;
    end else begin
      stg_lo_v <= cap_lo;
      stg_hi_v <= cap_hi;
      if (cap_lo) begin
        stg_lo_word <= addr_lo_dc3[DCCM_BITS-1:2];
        stg_lo_data <= sec_data_lo_dc3;
      end
      if (cap_hi) begin
        stg_hi_word <= addr_hi_dc3[DCCM_BITS-1:2];
        stg_hi_data <= sec_data_hi_dc3;
      end
    end
  end

  // Granted heads leave in REQ; store-invalidated heads are retired from IDLE.
  always_comb begin
    if (state == REQ) pop = wb_gnt;
    else              pop = (occ != '0) && !q_vld[rd_ptr];
  end

  // A same-cycle store to the staged word makes it stale before it is queued.
  assign cand_lo = stg_lo_v & ~(st_wen & (stg_lo_word == st_word));
  assign cand_hi = stg_hi_v & ~(st_wen & (stg_hi_word == st_word));

  // A slot freed by this cycle's pop is usable by this cycle's enqueue.
  assign free   = OW'(DEPTH) - occ + OW'(pop);
  assign acc_lo = cand_lo & (free != '0);
  assign acc_hi = cand_hi & (free > OW'(acc_lo));
  assign drop   = (cand_lo & ~acc_lo) | (cand_hi & ~acc_hi);
  assign n_acc  = {1'b0, acc_lo} + {1'b0, acc_hi};

  assign wr_hi_ptr  = wr_ptr + PW'(acc_lo);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign wr_ptr_nxt = wr_ptr + PW'(n_acc);
  assign occ_nxt    = occ + OW'(n_acc) - OW'(pop);
  assign cnt_sum    = {1'b0, err_count} + (CNT_WIDTH+1)'(n_acc);

  always_comb begin
    q_vld_nxt = q_vld;
    if (st_wen) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (q_word[i] == st_word) q_vld_nxt[i] = 1'b0;
      end
    end
    if (pop)    q_vld_nxt[rd_ptr]    = 1'b0;
    if (acc_lo) q_vld_nxt[wr_ptr]    = 1'b1;
    if (acc_hi) q_vld_nxt[wr_hi_ptr] = 1'b1;
  end

  assign head_ready_nxt = (occ_nxt != '0) && q_vld_nxt[rd_ptr_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      q_full    <= 1'b0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      q_vld     <= q_vld_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      occ       <= occ_nxt;
      q_full    <= (occ_nxt == OW'(DEPTH));
      overflow  <= drop;
      err_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  // Payload storage needs no reset; validity is tracked in q_vld.
  always_ff @(posedge clk) begin
    if (acc_lo) begin
      q_word[wr_ptr] <= stg_lo_word;
      q_data[wr_ptr] <= stg_lo_data;
    end
    if (acc_hi) begin
      q_word[wr_hi_ptr] <= stg_hi_word;
      q_data[wr_hi_ptr] <= stg_hi_data;
    end
  end

  // Writeback FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state is judged on the post-update queue so a grant can be followed
  // by a back-to-back request, and a store hitting the head drops the request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (head_ready_nxt)  state_nxt = REQ;
      REQ:     if (!head_ready_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_req  = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    if (state == REQ) begin
      wb_req  = 1'b1;
      wb_addr = {q_word[rd_ptr], 2'b00};
      wb_data = q_data[rd_ptr];
    end
  end

endmodule
